// File: rtl/periph_int_sched_if.sv
// Bus bundle between the interrupt read scheduler, the peripheral blocks and the CPU event port.
interface periph_int_sched_if #(
    parameter int unsigned N_PER = 4
);
    logic [N_PER-1:0] per_int;
    logic [N_PER-1:0] int_mask;
    logic [N_PER-1:0] per_drdy;
    logic [23:0]      per_data;
    logic [N_PER-1:0] per_ce;
    logic [1:0]       per_addr;
    logic             evt_valid;
    logic [1:0]       evt_src;
    logic [23:0]      evt_data;
    logic             evt_ack;
    logic             timeout_err;
    logic             busy;

    modport master (
        input  per_int, int_mask, per_drdy, per_data, evt_ack,
        output per_ce, per_addr, evt_valid, evt_src, evt_data, timeout_err, busy
    );

    modport slave (
        output per_int, int_mask, per_drdy, per_data, evt_ack,
        input  per_ce, per_addr, evt_valid, evt_src, evt_data, timeout_err, busy
    );
endinterface

// File: rtl/periph_int_sched.sv
// Round-robin interrupt-driven read scheduler: services one pending peripheral at a time
// and hands the captured word to the CPU through a valid/ack event port.
module periph_int_sched #(
    parameter int unsigned N_PER   = 4,
    parameter logic [1:0]  RD_ADDR = 2'b00,
    parameter int unsigned TIMEOUT = 2048
) (
    input  logic               clk,
    input  logic               rst,
    periph_int_sched_if.master bus
);
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [N_PER-1:0]  ce_q, ce_d;
    logic [1:0]        addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [1:0]        src_q, src_d;
    logic [23:0]       data_q, data_d;
    logic              terr_q, terr_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        g_q, g_d;
    logic [1:0]        rr_q, rr_d;

    logic [N_PER-1:0]  pending;
    logic              found;
    logic [1:0]        grant;
    logic [N_PER-1:0]  grant_oh;
    logic              drdy_sel;

    assign pending = bus.per_int & ~bus.int_mask;

    // Search upward from rr_q with wrap; the first hit wins.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        grant_oh = '0;
        for (int unsigned i = 0; i < N_PER; i++) begin
            for (int unsigned j = 0; j < N_PER; j++) begin
                if (!found && pending[j] && (((32'(rr_q) + i) % N_PER) == j)) begin
                    found       = 1'b1;
                    grant       = 2'(j);
                    grant_oh[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        drdy_sel = 1'b0;
        for (int unsigned j = 0; j < N_PER; j++) begin
            if (32'(g_q) == j) begin
                drdy_sel = bus.per_drdy[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ce_d    = ce_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        src_d   = src_q;
        data_d  = data_q;
        terr_d  = 1'b0;
        cnt_d   = cnt_q;
        g_d     = g_q;
        rr_d    = rr_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_REQ;
                    g_d     = grant;
                    ce_d    = grant_oh;
                    addr_d  = RD_ADDR;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                // drdy takes priority over a timeout landing in the same cycle
                if (drdy_sel) begin
                    data_d  = bus.per_data;
                    src_d   = g_q;
                    valid_d = 1'b1;
                    ce_d    = '0;
                    addr_d  = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    ce_d    = '0;
                    addr_d  = '0;
                    terr_d  = 1'b1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.evt_ack) begin
                    valid_d = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (32'(g_q) + 32'd1 >= N_PER) begin
                    rr_d = '0;
                end else begin
                    rr_d = g_q + 2'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ce_d    = '0;
                addr_d  = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ce_q    <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            data_q  <= '0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            g_q     <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            data_q  <= data_d;
            terr_q  <= terr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.per_ce      = ce_q;
    assign bus.per_addr    = addr_q;
    assign bus.evt_valid   = valid_q;
    assign bus.evt_src     = src_q;
    assign bus.evt_data    = data_q;
    assign bus.timeout_err = terr_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_periph_int_sched.sv
// Directed bench for periph_int_sched with a simple peripheral responder model.
module tb_periph_int_sched;
    logic clk = 1'b0;
    logic rst;

    int vectors    = 0;
    int miscompares = 0;

    // Responder model controls
    logic        resp_en;
    int unsigned resp_delay;
    logic        data_fixed;
    logic [23:0] fixed_data;
    logic [3:0]  stray_drdy;
    int unsigned ce_age = 0;
    logic [1:0]  ce_idx;
    logic        hit;

    periph_int_sched_if #(.N_PER(4)) bus ();

    periph_int_sched #(
        .N_PER  (4),
        .RD_ADDR(2'b10),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.per_ce != 4'b0) ce_age <= ce_age + 1;
        else                    ce_age <= 0;
    end

    always_comb begin
        ce_idx = 2'd0;
        for (int i = 0; i < 4; i++) if (bus.per_ce[i]) ce_idx = 2'(i);
    end

    assign hit          = resp_en && (bus.per_ce != 4'b0) && (ce_age == resp_delay - 1);
    assign bus.per_drdy = (hit ? bus.per_ce : 4'b0) | stray_drdy;
    assign bus.per_data = data_fixed ? fixed_data : {22'h0, ce_idx};

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        bus.evt_ack = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!bus.busy && !bus.evt_valid) break;
        end
        bus.evt_ack = 1'b0;
        vectors++;
        if (n == 50) begin
            miscompares++;
            $display("FAIL idle_wait: busy=%0b valid=%0b, expected idle within 50 cycles", bus.busy, bus.evt_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.per_ce, bus.per_addr, bus.evt_valid, bus.evt_src, bus.evt_data, bus.timeout_err, bus.busy} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: ce=%b addr=%b valid=%b src=%0d data=%h terr=%b busy=%b, expected all 0",
                     bus.per_ce, bus.per_addr, bus.evt_valid, bus.evt_src, bus.evt_data, bus.timeout_err, bus.busy);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.per_ce !== 4'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: busy=%b ce=%b, expected 0/0000", bus.busy, bus.per_ce);
        end
    endtask

    task automatic test_single();
        int n;
        resp_en = 1'b1; resp_delay = 3; data_fixed = 1'b1; fixed_data = 24'hA5A5A5;
        bus.evt_ack = 1'b0;
        bus.per_int = 4'b0001;
        @(negedge clk);
        vectors++;
        if (bus.per_ce !== 4'b0001 || bus.per_addr !== 2'b10 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_req: ce=%b addr=%b busy=%b, expected 0001/10/1", bus.per_ce, bus.per_addr, bus.busy);
        end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.per_ce == 4'b0001) n++;
            else break;
        end
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL single_ce_len: got %0d cycles, expected 3", n);
        end
        vectors++;
        if (bus.evt_valid !== 1'b1 || bus.evt_src !== 2'd0 || bus.evt_data !== 24'hA5A5A5 || bus.per_addr !== 2'b00) begin
            miscompares++;
            $display("FAIL single_event: valid=%b src=%0d data=%h addr=%b, expected 1/0/a5a5a5/00",
                     bus.evt_valid, bus.evt_src, bus.evt_data, bus.per_addr);
        end
        bus.per_int = 4'b0000;
        bus.evt_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.evt_valid !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ack: valid=%b busy=%b, expected 0/1", bus.evt_valid, bus.busy);
        end
        bus.evt_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: busy=%b, expected 0", bus.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_src [0:5];
        int k, last, bad;
        exp_src = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        k = 0; last = 0; bad = 0;
        do_reset();
        resp_en = 1'b1; resp_delay = 1; data_fixed = 1'b0;
        bus.evt_ack = 1'b1;
        bus.per_int = 4'b1011;
        for (int cyc = 0; cyc < 60 && k < 6; cyc++) begin
            @(negedge clk);
            if (bus.per_ce[2]) bad++;
            if (bus.evt_valid) begin
                vectors++;
                if (bus.evt_src !== exp_src[k] || bus.evt_data !== {22'h0, exp_src[k]}) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: src=%0d data=%h, expected %0d", k, bus.evt_src, bus.evt_data, exp_src[k]);
                end
                if (k > 0) begin
                    vectors++;
                    if (cyc - last != 4) begin
                        miscompares++;
                        $display("FAIL rr_period[%0d]: got %0d cycles, expected 4", k, cyc - last);
                    end
                end
                last = cyc;
                k++;
            end
        end
        bus.per_int = 4'b0000;
        vectors++;
        if (k != 6 || bad != 0) begin
            miscompares++;
            $display("FAIL rr_summary: events=%0d src2_ce_cycles=%0d, expected 6/0", k, bad);
        end
        wait_idle();
    endtask

    task automatic test_timeout();
        int ce_n, terr_n, valid_n, other;
        ce_n = 0; terr_n = 0; valid_n = 0; other = 0;
        resp_en = 1'b0;
        bus.evt_ack = 1'b0;
        bus.per_int = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.per_ce == 4'b0100) ce_n++;
            else if (bus.per_ce != 4'b0) other++;
            if (bus.evt_valid) valid_n++;
            if (bus.timeout_err) begin
                terr_n++;
                break;
            end
        end
        vectors++;
        if (ce_n != 16 || other != 0) begin
            miscompares++;
            $display("FAIL timeout_ce_len: ce2 cycles=%0d other=%0d, expected 16/0", ce_n, other);
        end
        vectors++;
        if (terr_n != 1 || valid_n != 0) begin
            miscompares++;
            $display("FAIL timeout_pulse: terr=%0d valid=%0d, expected 1/0", terr_n, valid_n);
        end
        resp_en = 1'b1; resp_delay = 1;
        bus.per_int = 4'b1101;
        @(negedge clk);
        vectors++;
        if (bus.timeout_err !== 1'b0 || bus.per_ce !== 4'b0 || bus.evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_end: terr=%b ce=%b valid=%b, expected 0/0000/0", bus.timeout_err, bus.per_ce, bus.evt_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.per_ce !== 4'b1000) begin
            miscompares++;
            $display("FAIL timeout_rr_next: ce=%b, expected 1000", bus.per_ce);
        end
        bus.per_int = 4'b0000;
        wait_idle();
    endtask

    task automatic test_hold_stall();
        int bad;
        bad = 0;
        resp_en = 1'b1; resp_delay = 1; data_fixed = 1'b1; fixed_data = 24'h123456;
        bus.evt_ack = 1'b0;
        bus.per_int = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.evt_valid) break;
        end
        vectors++;
        if (bus.evt_valid !== 1'b1 || bus.evt_src !== 2'd0 || bus.evt_data !== 24'h123456) begin
            miscompares++;
            $display("FAIL hold_event: valid=%b src=%0d data=%h, expected 1/0/123456", bus.evt_valid, bus.evt_src, bus.evt_data);
        end
        bus.per_int = 4'b0010;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.evt_valid !== 1'b1 || bus.evt_src !== 2'd0 || bus.evt_data !== 24'h123456 ||
                bus.per_ce !== 4'b0 || bus.busy !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_stable: %0d unstable cycles, expected 0", bad);
        end
        bus.evt_ack = 1'b1;
        @(negedge clk);
        bus.evt_ack = 1'b0;
        vectors++;
        if (bus.evt_valid !== 1'b0 || bus.per_ce !== 4'b0) begin
            miscompares++;
            $display("FAIL hold_gap: valid=%b ce=%b, expected 0/0000", bus.evt_valid, bus.per_ce);
        end
        @(negedge clk);
        vectors++;
        if (bus.per_ce !== 4'b0) begin
            miscompares++;
            $display("FAIL hold_idle_ce: ce=%b, expected 0000", bus.per_ce);
        end
        @(negedge clk);
        vectors++;
        if (bus.per_ce !== 4'b0010) begin
            miscompares++;
            $display("FAIL hold_next_grant: ce=%b, expected 0010", bus.per_ce);
        end
        bus.per_int = 4'b0000;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        resp_en = 1'b0;
        bus.evt_ack = 1'b0;
        bus.per_int = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.per_ce != 4'b0) break;
        end
        vectors++;
        if (bus.per_ce !== 4'b1000) begin
            miscompares++;
            $display("FAIL rstmid_grant: ce=%b, expected 1000", bus.per_ce);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.per_ce !== 4'b0 || bus.busy !== 1'b0 || bus.evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_drop: ce=%b busy=%b valid=%b, expected 0000/0/0", bus.per_ce, bus.busy, bus.evt_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1'b1; resp_delay = 1;
        @(negedge clk);
        vectors++;
        if (bus.per_ce !== 4'b1000 || bus.per_addr !== 2'b10) begin
            miscompares++;
            $display("FAIL rstmid_reserve: ce=%b addr=%b, expected 1000/10", bus.per_ce, bus.per_addr);
        end
        bus.per_int = 4'b0000;
        wait_idle();
    endtask

    task automatic test_mask();
        int bad;
        bad = 0;
        resp_en = 1'b1; resp_delay = 1;
        bus.int_mask = 4'b0001;
        bus.per_int  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.per_ce !== 4'b0 || bus.busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mask_blocks: %0d active cycles, expected 0", bad);
        end
        bus.int_mask = 4'b0000;
        @(negedge clk);
        vectors++;
        if (bus.per_ce !== 4'b0001) begin
            miscompares++;
            $display("FAIL mask_release: ce=%b, expected 0001", bus.per_ce);
        end
        bus.per_int = 4'b0000;
        wait_idle();
    endtask

    task automatic test_late_mask_stray();
        int bad;
        bad = 0;
        resp_en = 1'b0; data_fixed = 1'b1; fixed_data = 24'hBEEF01;
        bus.evt_ack = 1'b0;
        bus.per_int = 4'b0001;
        @(negedge clk);
        vectors++;
        if (bus.per_ce !== 4'b0001) begin
            miscompares++;
            $display("FAIL late_grant: ce=%b, expected 0001", bus.per_ce);
        end
        bus.int_mask = 4'b0001;
        bus.per_int  = 4'b0000;
        stray_drdy   = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.per_ce !== 4'b0001 || bus.evt_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stray_drdy: %0d bad cycles, expected 0", bad);
        end
        stray_drdy = 4'b0001;
        @(negedge clk);
        stray_drdy = 4'b0000;
        vectors++;
        if (bus.evt_valid !== 1'b1 || bus.evt_src !== 2'd0 || bus.evt_data !== 24'hBEEF01 || bus.per_ce !== 4'b0) begin
            miscompares++;
            $display("FAIL late_complete: valid=%b src=%0d data=%h ce=%b, expected 1/0/beef01/0000",
                     bus.evt_valid, bus.evt_src, bus.evt_data, bus.per_ce);
        end
        bus.int_mask = 4'b0000;
        wait_idle();
    endtask

    initial begin
        rst          = 1'b1;
        bus.per_int  = 4'b0;
        bus.int_mask = 4'b0;
        bus.evt_ack  = 1'b0;
        stray_drdy   = 4'b0;
        resp_en      = 1'b1;
        resp_delay   = 1;
        data_fixed   = 1'b0;
        fixed_data   = 24'h0;

        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_hold_stall();
        test_reset_mid();
        test_mask();
        test_late_mask_stray();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
